// File: rtl/btb_update_ctrl.sv
// rtl/btb_update_ctrl.sv - BTB write-port controller: in-order update queue, invalidate sweep,
// optional lookup forwarding of pending writes when BTB_BYPASS_EN is defined.
module btb_update_ctrl #(
  parameter int ADDR_W  = 13,
  parameter int BIA_W   = 8,
  parameter int BTA_W   = 32,
  parameter int NUM_UPD = 2,
  parameter int DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_UPD-1:0]        upd_valid,
  input  logic [NUM_UPD*ADDR_W-1:0] upd_addr,
  input  logic [NUM_UPD-1:0]        upd_v,
  input  logic [NUM_UPD*BIA_W-1:0]  upd_bia,
  input  logic [NUM_UPD*BTA_W-1:0]  upd_bta,
  output logic                      upd_ready,
  input  logic                      clr_req,
  output logic                      clr_busy,
  output logic                      btb_wen,
  output logic [ADDR_W-1:0]         btb_waddr,
  output logic                      btb_v,
  output logic [BIA_W-1:0]          btb_bia,
  output logic [BTA_W-1:0]          btb_bta,
  input  logic [ADDR_W-1:0]         lk_addr,
  output logic                      lk_hit,
  output logic                      lk_v,
  output logic [BIA_W-1:0]          lk_bia,
  output logic [BTA_W-1:0]          lk_bta
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NW = $clog2(NUM_UPD + 1);

  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state;

  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic              q_v    [DEPTH];
  logic [BIA_W-1:0]  q_bia  [DEPTH];
  logic [BTA_W-1:0]  q_bta  [DEPTH];

  logic [PW-1:0] slot [NUM_UPD];
  logic [NW-1:0] push_n;
  logic          pop;

  assign upd_ready = (state == IDLE) && !clr_req && (count <= CW'(DEPTH - NUM_UPD));
  assign pop       = (state == IDLE) && !clr_req && (count != '0);
  assign clr_busy  = (state == CLEAR);

  // Valid ports take consecutive slots after tail so the queue has no holes.
  always_comb begin
    push_n = '0;
    for (int i = 0; i < NUM_UPD; i++) begin
      slot[i] = tail + PW'(push_n);
      if (upd_valid[i]) push_n = push_n + NW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (upd_ready) begin
      for (int i = 0; i < NUM_UPD; i++) begin
        if (upd_valid[i]) begin
          q_addr[slot[i]] <= upd_addr[i*ADDR_W +: ADDR_W];
          q_v[slot[i]]    <= upd_v[i];
          q_bia[slot[i]]  <= upd_bia[i*BIA_W +: BIA_W];
          q_bta[slot[i]]  <= upd_bta[i*BTA_W +: BTA_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      cnt       <= '0;
      btb_wen   <= 1'b0;
      btb_waddr <= '0;
      btb_v     <= 1'b0;
      btb_bia   <= '0;
      btb_bta   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            // Queued updates are stale once the table is wiped, so drop them.
            state     <= CLEAR;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            cnt       <= '0;
            btb_wen   <= 1'b1;
            btb_waddr <= '0;
            btb_v     <= 1'b0;
            btb_bia   <= '0;
            btb_bta   <= '0;
          end else begin
            btb_wen <= pop;
            if (pop) begin
              btb_waddr <= q_addr[head];
              btb_v     <= q_v[head];
              btb_bia   <= q_bia[head];
              btb_bta   <= q_bta[head];
              head      <= head + PW'(1);
            end
            if (upd_ready) tail <= tail + PW'(push_n);
            count <= count + (upd_ready ? CW'(push_n) : CW'(0)) - CW'(pop);
          end
        end
        CLEAR: begin
          if (cnt == '1) begin
            state   <= IDLE;
            btb_wen <= 1'b0;
          end else begin
            cnt       <= cnt + ADDR_W'(1);
            btb_waddr <= cnt + ADDR_W'(1);
            btb_wen   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BTB_BYPASS_EN
  logic [PW-1:0] idx;

  // Later (younger) queue matches override earlier ones; the output register ranks lowest.
  always_comb begin
    lk_hit = 1'b0;
    lk_v   = 1'b0;
    lk_bia = '0;
    lk_bta = '0;
    idx    = '0;
    if (state == CLEAR) begin
      lk_hit = 1'b1;
    end else begin
      if (btb_wen && btb_waddr == lk_addr) begin
        lk_hit = 1'b1;
        lk_v   = btb_v;
        lk_bia = btb_bia;
        lk_bta = btb_bta;
      end
      for (int j = 0; j < DEPTH; j++) begin
        idx = head + PW'(j);
        if (CW'(j) < count && q_addr[idx] == lk_addr) begin
          lk_hit = 1'b1;
          lk_v   = q_v[idx];
          lk_bia = q_bia[idx];
          lk_bta = q_bta[idx];
        end
      end
    end
  end
`else
  logic unused_lk;
  assign unused_lk = ^lk_addr;
  assign lk_hit    = 1'b0;
  assign lk_v      = 1'b0;
  assign lk_bia    = '0;
  assign lk_bta    = '0;
`endif
endmodule

// File: doc/btb_update_ctrl.md
Name: btb_update_ctrl

Overview:
- Write-side controller for the 2^13-entry BTB (V, BIA, BTA per entry); sits between the commit stage and the BTB's single write port.
- Accepts up to NUM_UPD branch-resolution updates per cycle and buffers them in an in-order queue. Drains the queue one write per cycle.
- Sequences a full-table invalidate sweep on request.
- Optionally forwards still-queued updates to the fetch-side lookup so a read never sees a stale entry.

Parameters:
ADDR_W, 13, BTB index width; table size 2^ADDR_W
BIA_W, 8, branch-instruction-address tag width
BTA_W, 32, branch target width
NUM_UPD, 2, update ports per cycle
DEPTH, 4, queue entries; must be a power of two and >= NUM_UPD

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
upd_valid  in  NUM_UPD  per-port update request
upd_addr  in  NUM_UPD*ADDR_W  packed index, port i at [i*ADDR_W +: ADDR_W]
upd_v  in  NUM_UPD  valid bit to write
upd_bia  in  NUM_UPD*BIA_W  packed tag
upd_bta  in  NUM_UPD*BTA_W  packed target
upd_ready  out  1  all ports accepted this cycle when high
clr_req  in  1  start invalidate sweep (level, sampled in IDLE)
clr_busy  out  1  sweep in progress
btb_wen  out  1  BTB write enable (registered)
btb_waddr  out  ADDR_W  BTB write index (registered)
btb_v  out  1  registered
btb_bia  out  BIA_W  registered
btb_bta  out  BTA_W  registered
lk_addr  in  ADDR_W  fetch lookup index
lk_hit  out  1  lookup matches a pending write (bypass only)
lk_v  out  1  forwarded V
lk_bia  out  BIA_W  forwarded BIA
lk_bta  out  BTA_W  forwarded BTA

Behaviour:
- Reset: state=IDLE, queue empty (head=tail=count=0), sweep counter 0. All btb_* outputs 0, clr_busy=0, lk_* = 0.
- upd_ready = (state==IDLE) && !clr_req && (DEPTH-count >= NUM_UPD). It is combinational and independent of upd_valid.
- Enqueue: at an edge with upd_ready=1, every port with upd_valid=1 is enqueued in port order 0..NUM_UPD-1, compacted with no holes. Invalid ports consume no slot.
- Drain in IDLE: if count>0 (count as before the edge), the head is popped at the edge and loaded into the btb_* registers with btb_wen=1. Otherwise btb_wen=0 after the edge.
- Push and pop in the same cycle are allowed; count updates by pushes minus pop.
- Latency: an update accepted at edge k into an empty queue appears on btb_* in the cycle after edge k+1.
- Ordering: writes leave in strict acceptance order, so the last update to an index wins.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH and is never exceeded, because of the upd_ready rule.
- FSM IDLE -> CLEAR: at an edge with state==IDLE && clr_req=1.
  - The queue is discarded (count=0); pending updates are stale after a clear.
  - The counter is set to 0 and clr_busy=1 from the next cycle.
- CLEAR: each cycle btb_wen=1, btb_waddr=cnt, btb_v=0, btb_bia=0, btb_bta=0; cnt increments.
- CLEAR -> IDLE: after the write with cnt=2^ADDR_W-1 is registered. The sweep lasts exactly 2^ADDR_W consecutive write cycles; clr_busy drops on the edge following the last one.
- clr_req during CLEAR is ignored; no restart.
- rst during CLEAR aborts at once: IDLE, btb_wen=0, and the table is left partially cleared.
- The btb_* registers hold their last address/data when btb_wen=0; only btb_wen is meaningful.

Optional Feature:
BTB_BYPASS_EN
- With: combinational compare of lk_addr against every valid queue entry and against the registered btb_* (when btb_wen=1).
  - Priority: youngest queue entry first, then oldest queue entry, then the btb_* register.
  - lk_hit=1 with that entry's V/BIA/BTA.
  - In CLEAR: lk_hit=1, lk_v=0 for every lk_addr.
- Without: lk_hit, lk_v, lk_bia, lk_bta are tied to 0 and no compare logic is built.

Test Plan:
- Reset, then upd_valid=2'b11, addr0=0x010 V=1 BIA=0x12 BTA=0x80000010, addr1=0x011 BTA=0x80000020 -> btb_wen high for 2 consecutive cycles starting 2 cycles after acceptance, addr 0x010 then 0x011.
- Stall drain by holding the queue occupancy: issue 2 pairs back-to-back with DEPTH=4 -> upd_ready=0 when count=3 or 4, no entry lost, 4 writes in order.
- Same index twice (port0 0x020 BTA=0xA, port1 0x020 BTA=0xB) -> two writes, last btb_bta=0xB.
- clr_req with 3 entries queued -> queue dropped, no write of those entries, 8192 writes addr 0..0x1FFF with V=0, clr_busy high 8192 cycles, upd_ready=0 throughout.
- rst asserted at sweep cycle 100 -> next cycle btb_wen=0, clr_busy=0, upd_ready=1.
- BTB_BYPASS_EN: queue 0x030 BTA=0x1 then 0x030 BTA=0x2, lk_addr=0x030 -> lk_hit=1, lk_bta=0x2. lk_addr=0x031 -> lk_hit=0.
